// File: rtl/xpar_resp.sv
// rtl/xpar_resp.sv - picoVersat parallel-bus responder: scratch, status, TX/RX mailboxes
// Word FIFO holding the mailbox data; RAM contents survive reset, only pointers clear.

module xpar_resp_fifo #(
   parameter int DW = 32,
   parameter int AW = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [DW-1:0] push_data,
   input  logic          pop,
   output logic [DW-1:0] head,
   output logic [AW:0]   count,
   output logic          full,
   output logic          empty
);

   localparam int DEPTH = 1 << AW;
   localparam logic [AW:0] DEPTH_CNT = DEPTH[AW:0];

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == DEPTH_CNT);
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointers wrap naturally at AW bits; count carries the extra bit for full.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// Responder decoding an 8-word window at BASE on the core's parallel bus.
module xpar_resp #(
   parameter int DATA_W     = 32,
   parameter int PAR_ADDR_W = 12,
   parameter int BASE       = 0,
   parameter int FIFO_AW    = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [PAR_ADDR_W-1:0] par_addr,
   input  logic                  par_we,
   input  logic [DATA_W-1:0]     par_out,
   output logic [DATA_W-1:0]     par_in,
   output logic [DATA_W-1:0]     tx_data,
   output logic                  tx_valid,
   input  logic                  tx_ready,
   input  logic [DATA_W-1:0]     rx_data,
   input  logic                  rx_valid,
   output logic                  rx_ready
);

   localparam logic [PAR_ADDR_W-4:0] BASE_F = (PAR_ADDR_W-3)'(BASE);

   localparam logic [2:0] OFF_SCRATCH = 3'd0;
   localparam logic [2:0] OFF_STATUS  = 3'd1;
   localparam logic [2:0] OFF_TX_DATA = 3'd2;
   localparam logic [2:0] OFF_RX_DATA = 3'd3;
   localparam logic [2:0] OFF_RX_POP  = 3'd4;

   logic              sel;
   logic [2:0]        off;
   logic              wr;
   logic [DATA_W-1:0] scratch;
   logic              tx_ovf;
   logic              rx_pop_err;

   logic              tx_push_req;
   logic              tx_push;
   logic              tx_pop;
   logic [FIFO_AW:0]  tx_count;
   logic              tx_full;
   logic              tx_empty;

   logic              rx_pop_req;
   logic              rx_push;
   logic              rx_pop;
   logic [DATA_W-1:0] rx_head;
   logic [FIFO_AW:0]  rx_count;
   logic              rx_full;
   logic              rx_empty;

   logic              w1c_ovf;
   logic              w1c_perr;
   logic [31:0]       status_w;

   assign sel = (par_addr[PAR_ADDR_W-1:3] == BASE_F);
   assign off = par_addr[2:0];
   assign wr  = par_we & sel;

   assign tx_push_req = wr & (off == OFF_TX_DATA);
   assign tx_push     = tx_push_req & ~tx_full;
   assign tx_pop      = tx_valid & tx_ready;
   assign tx_valid    = ~tx_empty;

   assign rx_pop_req = wr & (off == OFF_RX_POP);
   assign rx_pop     = rx_pop_req & ~rx_empty;
   assign rx_ready   = ~rx_full;
   assign rx_push    = rx_valid & rx_ready;

   assign w1c_ovf  = wr & (off == OFF_STATUS) & par_out[4];
   assign w1c_perr = wr & (off == OFF_STATUS) & par_out[5];

   xpar_resp_fifo #(
      .DW (DATA_W),
      .AW (FIFO_AW)
   ) u_tx_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (tx_push),
      .push_data (par_out),
      .pop       (tx_pop),
      .head      (tx_data),
      .count     (tx_count),
      .full      (tx_full),
      .empty     (tx_empty)
   );

   xpar_resp_fifo #(
      .DW (DATA_W),
      .AW (FIFO_AW)
   ) u_rx_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (rx_push),
      .push_data (rx_data),
      .pop       (rx_pop),
      .head      (rx_head),
      .count     (rx_count),
      .full      (rx_full),
      .empty     (rx_empty)
   );

   // Sticky flags: a set in the same cycle as its W1C takes priority.
   always_ff @(posedge clk) begin
      if (!rst) begin
         scratch    <= '0;
         tx_ovf     <= 1'b0;
         rx_pop_err <= 1'b0;
      end else begin
         if (wr && (off == OFF_SCRATCH)) begin
            scratch <= par_out;
         end
         tx_ovf     <= (tx_ovf & ~w1c_ovf) | (tx_push_req & tx_full);
         rx_pop_err <= (rx_pop_err & ~w1c_perr) | (rx_pop_req & rx_empty);
      end
   end

   assign status_w = {8'h00, 8'(rx_count), 8'(tx_count), 2'b00,
                      rx_pop_err, tx_ovf, rx_empty, rx_full, tx_empty, tx_full};

   always_comb begin
      par_in = '0;
      if (sel) begin
         case (off)
            OFF_SCRATCH: par_in = scratch;
            OFF_STATUS:  par_in = DATA_W'(status_w);
            OFF_RX_DATA: par_in = rx_empty ? '0 : rx_head;
            default:     par_in = '0;
         endcase
      end
   end

endmodule
